// File: rtl/counter_pkg.sv
// Shared encodings for the counter tick controller: run modes, FSM states,
// and the prescaler divide value loaded at reset.
package counter_pkg;

  localparam logic [1:0] MODE_FREE       = 2'd0;
  localparam logic [1:0] MODE_ONESHOT_UP = 2'd1;
  localparam logic [1:0] MODE_ONESHOT_DN = 2'd2;
  localparam logic [1:0] MODE_RSVD       = 2'd3;

  localparam int DEFAULT_DIV = 213;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  // The reserved encoding behaves as free-run, so it is folded away at load time.
  function automatic logic [1:0] norm_mode(input logic [1:0] m);
    return (m == MODE_RSVD) ? MODE_FREE : m;
  endfunction

endpackage

// File: rtl/tick_prescaler.sv
// Programmable prescaler: raises tick for one cycle every max(div,1) enabled
// cycles. tick is combinational so the parent can register it with the count.
module tick_prescaler #(
  parameter int DIV_W = 26
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             clr,
  input  logic [DIV_W-1:0] div,
  output logic             tick
);

  logic [DIV_W-1:0] pcnt;
  logic [DIV_W-1:0] eff_div_m1;

  // A divide value of zero is treated as one (tick every cycle).
  assign eff_div_m1 = (div == '0) ? '0 : div - DIV_W'(1);
  assign tick       = en && !clr && (pcnt == eff_div_m1);

  always_ff @(posedge clk) begin
    if (rst || clr) begin
      pcnt <= '0;
    end else if (en) begin
      pcnt <= tick ? '0 : pcnt + DIV_W'(1);
    end
  end

endmodule

// File: rtl/counter_tick_ctrl.sv
// Run/stop/one-shot sequencer for the up/down counter, with a valid/ready
// configuration port and a prescaled tick enable.
module counter_tick_ctrl #(
  parameter int DIV_W       = 26,
  parameter int CNT_W       = 4,
  parameter int DEFAULT_DIV = counter_pkg::DEFAULT_DIV
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             cfg_valid,
  output logic             cfg_ready,
  input  logic [DIV_W-1:0] cfg_div,
  input  logic [CNT_W-1:0] cfg_limit,
  input  logic [1:0]       cfg_mode,
  input  logic             start,
  input  logic             stop,
  output logic             tick,
  output logic [CNT_W-1:0] count_out,
  output logic             busy,
  output logic             done
);

  import counter_pkg::*;

  state_t           st;
  state_t           st_nxt;
  logic [DIV_W-1:0] div_reg;
  logic [CNT_W-1:0] limit_reg;
  logic [1:0]       mode_reg;
  logic [CNT_W-1:0] count_q;
  logic [CNT_W-1:0] count_nxt;
  logic             tick_q;
  logic             tick_nxt;
  logic             busy_q;
  logic             done_q;
  logic             pre_en;
  logic             pre_clr;
  logic             pre_tick;
  logic             cfg_accept;

  // Free-run up: wrap to zero once the limit is reached, never past it.
  function automatic logic [CNT_W-1:0] up_wrap(input logic [CNT_W-1:0] c,
                                               input logic [CNT_W-1:0] lim);
    return (c >= lim) ? '0 : c + CNT_W'(1);
  endfunction

  // One-shot up: saturate at the limit (limit 0 stays at 0).
  function automatic logic [CNT_W-1:0] up_sat(input logic [CNT_W-1:0] c,
                                              input logic [CNT_W-1:0] lim);
    return (c >= lim) ? lim : c + CNT_W'(1);
  endfunction

  // One-shot down: saturate at zero.
  function automatic logic [CNT_W-1:0] dn_sat(input logic [CNT_W-1:0] c);
    return (c == '0) ? '0 : c - CNT_W'(1);
  endfunction

  assign cfg_ready  = (st == ST_IDLE) && !rst;
  assign cfg_accept = cfg_valid && (st == ST_IDLE);

  // Prescaler only runs in RUN; stop clears it in the same cycle it suppresses the tick.
  assign pre_en  = (st == ST_RUN);
  assign pre_clr = (st != ST_RUN) || stop;

  tick_prescaler #(
    .DIV_W (DIV_W)
  ) u_prescaler (
    .clk  (clk),
    .rst  (rst),
    .en   (pre_en),
    .clr  (pre_clr),
    .div  (div_reg),
    .tick (pre_tick)
  );

  always_comb begin
    st_nxt    = st;
    count_nxt = count_q;
    tick_nxt  = 1'b0;
    unique case (st)
      ST_IDLE: begin
        // Config has priority over start when both arrive together.
        if (!cfg_valid && start) begin
          st_nxt    = ST_RUN;
          count_nxt = (mode_reg == MODE_ONESHOT_DN) ? limit_reg : '0;
        end
      end
      ST_RUN: begin
        if (stop) begin
          st_nxt = ST_IDLE;
        end else if (pre_tick) begin
          tick_nxt = 1'b1;
          case (mode_reg)
            MODE_ONESHOT_UP: begin
              count_nxt = up_sat(count_q, limit_reg);
              if (count_nxt == limit_reg) st_nxt = ST_DONE;
            end
            MODE_ONESHOT_DN: begin
              count_nxt = dn_sat(count_q);
              if (count_nxt == '0) st_nxt = ST_DONE;
            end
            default: begin
              count_nxt = up_wrap(count_q, limit_reg);
            end
          endcase
        end
      end
      ST_DONE: begin
        st_nxt = ST_IDLE;
      end
      default: begin
        st_nxt = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      st        <= ST_IDLE;
      count_q   <= '0;
      tick_q    <= 1'b0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      div_reg   <= DIV_W'(DEFAULT_DIV);
      limit_reg <= '1;
      mode_reg  <= MODE_FREE;
    end else begin
      st      <= st_nxt;
      count_q <= count_nxt;
      tick_q  <= tick_nxt;
      busy_q  <= (st_nxt == ST_RUN);
      done_q  <= (st_nxt == ST_DONE);
      if (cfg_accept) begin
        div_reg   <= cfg_div;
        limit_reg <= cfg_limit;
        mode_reg  <= norm_mode(cfg_mode);
      end
    end
  end

  assign tick      = tick_q;
  assign count_out = count_q;
  assign busy      = busy_q;
  assign done      = done_q;

endmodule

// File: tb/tb_counter_tick_ctrl.sv
// Scoreboard bench for counter_tick_ctrl: a cycle model predicts every output
// sample, a monitor compares it one edge later.
module tb_counter_tick_ctrl;

  localparam int DIV_W = 26;
  localparam int CNT_W = 4;
  localparam int S_IDLE = 0;
  localparam int S_RUN  = 1;
  localparam int S_DONE = 2;

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic             cfg_valid = 1'b0;
  logic             cfg_ready;
  logic [DIV_W-1:0] cfg_div = '0;
  logic [CNT_W-1:0] cfg_limit = '0;
  logic [1:0]       cfg_mode = '0;
  logic             start = 1'b0;
  logic             stop = 1'b0;
  logic             tick;
  logic [CNT_W-1:0] count_out;
  logic             busy;
  logic             done;

  counter_tick_ctrl dut (
    .clk       (clk),
    .rst       (rst),
    .cfg_valid (cfg_valid),
    .cfg_ready (cfg_ready),
    .cfg_div   (cfg_div),
    .cfg_limit (cfg_limit),
    .cfg_mode  (cfg_mode),
    .start     (start),
    .stop      (stop),
    .tick      (tick),
    .count_out (count_out),
    .busy      (busy),
    .done      (done)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic       tick;
    logic [3:0] count;
    logic       busy;
    logic       done;
    logic       ready;
  } obs_t;

  obs_t exp_q[$];
  int   checks = 0;
  int   errors = 0;
  int   cycle  = 0;
  bit   armed  = 1'b0;
  bit   finished = 1'b0;

  // Reference model state, expressed in plain integers.
  int m_state = S_IDLE;
  int m_div = 213, m_limit = 15, m_mode = 0;
  int m_elapsed = 0, m_count = 0;
  bit m_tick = 0, m_busy = 0, m_done = 0;

  function automatic int eff_div();
    return (m_div == 0) ? 1 : m_div;
  endfunction

  task automatic model(input bit r, input bit cv, input int dv, input int lim,
                       input int md, input bit st, input bit sp);
    m_tick = 1'b0;
    if (r) begin
      m_state = S_IDLE; m_count = 0;
      m_div = 213; m_limit = 15; m_mode = 0;
    end else begin
      case (m_state)
        S_IDLE: begin
          if (cv) begin
            m_div = dv; m_limit = lim; m_mode = (md == 3) ? 0 : md;
          end else if (st) begin
            m_state = S_RUN; m_elapsed = 0;
            m_count = (m_mode == 2) ? m_limit : 0;
          end
        end
        S_RUN: begin
          if (sp) begin
            m_state = S_IDLE;
          end else begin
            m_elapsed++;
            if (m_elapsed % eff_div() == 0) begin
              m_tick = 1'b1;
              if (m_mode == 0) begin
                m_count = (m_count + 1) % (m_limit + 1);
              end else if (m_mode == 1) begin
                m_count = (m_count + 1 > m_limit) ? m_limit : m_count + 1;
                if (m_count == m_limit) m_state = S_DONE;
              end else begin
                m_count = (m_count == 0) ? 0 : m_count - 1;
                if (m_count == 0) m_state = S_DONE;
              end
            end
          end
        end
        default: m_state = S_IDLE;
      endcase
    end
    m_busy = (m_state == S_RUN);
    m_done = (m_state == S_DONE);
  endtask

  task automatic step(input bit r, input bit cv, input int dv, input int lim,
                      input int md, input bit st, input bit sp);
    obs_t e;
    @(negedge clk);
    rst = r; cfg_valid = cv; cfg_div = DIV_W'(dv); cfg_limit = CNT_W'(lim);
    cfg_mode = 2'(md); start = st; stop = sp;
    model(r, cv, dv, lim, md, st, sp);
    e.tick  = m_tick;
    e.count = 4'(m_count);
    e.busy  = m_busy;
    e.done  = m_done;
    e.ready = (m_state == S_IDLE) && !r;
    exp_q.push_back(e);
    armed = 1'b1;
  endtask

  task automatic idle();
    step(0, 0, 0, 0, 0, 0, 0);
  endtask

  task automatic cfg(input int dv, input int lim, input int md);
    step(0, 1, dv, lim, md, 0, 0);
  endtask

  task automatic go();
    step(0, 0, 0, 0, 0, 1, 0);
  endtask

  // Monitor: compare every presented output sample against the scoreboard.
  initial begin
    obs_t e, got;
    forever begin
      @(posedge clk);
      #1;
      cycle++;
      if (exp_q.size() > 0) begin
        e   = exp_q.pop_front();
        got = {tick, count_out, busy, done, cfg_ready};
        checks++;
        if (got !== e) begin
          errors++;
          $display("FAIL outputs cycle %0d: got tick=%0b count=%0d busy=%0b done=%0b ready=%0b, expected tick=%0b count=%0d busy=%0b done=%0b ready=%0b",
                   cycle, got.tick, got.count, got.busy, got.done, got.ready,
                   e.tick, e.count, e.busy, e.done, e.ready);
        end
      end else if (armed && !finished) begin
        checks++;
        errors++;
        $display("FAIL scoreboard_underflow cycle %0d: got empty queue, expected a pending sample", cycle);
      end
    end
  end

  initial begin
    #2000000;
    $display("FAIL timeout: got no completion, expected bench to finish");
    $fatal(1, "timeout");
  end

  initial begin
    bit hit;
    // Reset for three cycles, then a long idle with stray stop requests.
    repeat (3) step(1, 0, 0, 0, 0, 0, 0);
    for (int i = 0; i < 500; i++) step(0, 0, 0, 0, 0, 0, (i % 37) == 5);

    // Free-run wrap.
    cfg(4, 5, 0); go();
    repeat (40) idle();
    step(0, 0, 0, 0, 0, 0, 1); idle();

    // One-shot up, div 1.
    cfg(1, 3, 1); go();
    repeat (8) idle();

    // One-shot down, div 0 acting as 1.
    cfg(0, 2, 2); go();
    repeat (6) idle();

    // Stop collides with the cycle a tick would fire.
    cfg(3, 15, 0); go();
    for (int i = 0; i < 40; i++) begin
      hit = (m_state == S_RUN) && (((m_elapsed + 1) % eff_div()) == 0);
      if (hit && m_count >= 2) begin
        step(0, 0, 0, 0, 0, 0, 1);
        break;
      end
      idle();
    end
    repeat (3) idle();

    // Config and start together: config wins; start alone then runs.
    step(0, 1, 2, 6, 1, 1, 0);
    go();
    repeat (20) idle();

    // Limit 0 corner cases.
    cfg(1, 0, 1); go(); repeat (4) idle();
    cfg(1, 0, 0); go(); repeat (4) idle(); step(0, 0, 0, 0, 0, 0, 1);
    cfg(2, 0, 2); go(); repeat (4) idle();
    cfg(1, 15, 3); go(); repeat (20) idle(); step(0, 0, 0, 0, 0, 0, 1);

    // Reset mid-run, then default divide restored.
    cfg(2, 15, 0); go();
    for (int i = 0; i < 40 && m_count != 4; i++) idle();
    step(1, 0, 0, 0, 0, 0, 0);
    idle(); go();
    repeat (220) idle();
    step(0, 0, 0, 0, 0, 0, 1);

    // Randomized traffic.
    for (int i = 0; i < 3000; i++) begin
      step($urandom_range(0, 199) == 0, $urandom_range(0, 9) == 0,
           int'($urandom_range(0, 5)), int'($urandom_range(0, 15)),
           int'($urandom_range(0, 3)), $urandom_range(0, 3) == 0,
           $urandom_range(0, 15) == 0);
    end

    @(posedge clk);
    #2;
    finished = 1'b1;
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL drain: got %0d pending samples, expected 0", exp_q.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
